// File: rtl/alu_sequencer.sv
// Instruction sequencer for a small ALU. It fetches 16-bit words from program
// memory, decodes the ALU opcode class, strobes the ALU for one execute cycle,
// and owns the CARRY and SKIP flags plus the program counter. Any word whose
// top two bits are not 2'b11 stops the sequencer until the next reset.
module alu_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic [7:0]  mem_addr,
  output logic [15:0] instruction,
  output logic        exec1,
  output logic        carrystatus,
  output logic        skipstatus,
  input  logic        carryout,
  input  logic        carryen,
  input  logic        skipout,
  input  logic        skipen,
  input  logic        wenout,
  output logic        rf_we,
  output logic [1:0]  rf_waddr,
  output logic [1:0]  rf_raddr,
  output logic        halted
);

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StDecode,
    StExec1,
    StExec2,
    StHalt
  } state_e;

  state_e      state_q;
  logic [7:0]  pc_q;
  logic [15:0] ir_q;
  logic        carry_q;
  logic        skip_q;
  logic        mem_req_q;
  logic        exec1_q;
  logic        halted_q;

  // Sequencer FSM. The strobes are registered alongside the state: each one is
  // set on the edge that enters the state it belongs to, so it is high for
  // exactly the cycles spent in that state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      pc_q      <= 8'h00;
      ir_q      <= 16'h0000;
      carry_q   <= 1'b0;
      skip_q    <= 1'b0;
      mem_req_q <= 1'b0;
      exec1_q   <= 1'b0;
      halted_q  <= 1'b0;
    end else begin
      mem_req_q <= 1'b0;
      exec1_q   <= 1'b0;
      case (state_q)
        StIdle: begin
          if (start) begin
            state_q   <= StFetch;
            mem_req_q <= 1'b1;
          end
        end
        StFetch: begin
          if (mem_ready) begin
            ir_q    <= mem_rdata;
            pc_q    <= pc_q + 8'd1;
            state_q <= StDecode;
          end else begin
            // Request stays up until memory answers.
            mem_req_q <= 1'b1;
          end
        end
        StDecode: begin
          if (ir_q[15:14] == 2'b11) begin
            state_q <= StExec1;
            exec1_q <= 1'b1;
          end else begin
            state_q  <= StHalt;
            halted_q <= 1'b1;
          end
        end
        StExec1: begin
          if (carryen) carry_q <= carryout;
          if (skipen)  skip_q  <= skipout;
          state_q <= StExec2;
        end
        StExec2: begin
          // A pending skip steps over the next word and is consumed here.
          if (skip_q) begin
            pc_q   <= pc_q + 8'd1;
            skip_q <= 1'b0;
          end
          state_q   <= StFetch;
          mem_req_q <= 1'b1;
        end
        StHalt: begin
          // Only reset leaves this state; start is ignored.
          state_q <= StHalt;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  // exec1_q is high only in the execute cycle, so it also gates the Rd write.
  assign rf_we       = exec1_q & wenout;
  assign rf_waddr    = ir_q[3:2];
  assign rf_raddr    = ir_q[1:0];
  assign mem_req     = mem_req_q;
  assign mem_addr    = pc_q;
  assign instruction = ir_q;
  assign exec1       = exec1_q;
  assign carrystatus = carry_q;
  assign skipstatus  = skip_q;
  assign halted      = halted_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer. A memory responder serves words from a
// stream queue and checks every accepted fetch against an expected-fetch queue;
// a monitor checks every execute strobe against an expected-execute queue. The
// ALU is stood in for by wiring its flag/enable outputs to fixed IR bits.
module tb_alu_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] mem_rdata;
  logic        mem_ready;
  logic        mem_req;
  logic [7:0]  mem_addr;
  logic [15:0] instruction;
  logic        exec1;
  logic        carrystatus;
  logic        skipstatus;
  logic        carryout;
  logic        carryen;
  logic        skipout;
  logic        skipen;
  logic        wenout;
  logic        rf_we;
  logic [1:0]  rf_waddr;
  logic [1:0]  rf_raddr;
  logic        halted;

  always #5 clk = ~clk;

  // ALU stand-in: IR[8]=carryen, IR[9]=carryout, IR[10]=skipen,
  // IR[11]=skipout, IR[12]=wenout.
  assign carryen  = instruction[8];
  assign carryout = instruction[9];
  assign skipen   = instruction[10];
  assign skipout  = instruction[11];
  assign wenout   = instruction[12];

  alu_sequencer dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .mem_rdata   (mem_rdata),
    .mem_ready   (mem_ready),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .instruction (instruction),
    .exec1       (exec1),
    .carrystatus (carrystatus),
    .skipstatus  (skipstatus),
    .carryout    (carryout),
    .carryen     (carryen),
    .skipout     (skipout),
    .skipen      (skipen),
    .wenout      (wenout),
    .rf_we       (rf_we),
    .rf_waddr    (rf_waddr),
    .rf_raddr    (rf_raddr),
    .halted      (halted)
  );

  typedef struct packed {
    logic [7:0] addr;
    logic       carry;
    logic       skip;
  } fetch_t;

  typedef struct packed {
    logic [15:0] instr;
    logic        we;
    logic [1:0]  waddr;
    logic [1:0]  raddr;
    logic        chk_flags;
    logic        carry;
    logic        skip;
  } exec_t;

  fetch_t      fetch_q[$];
  exec_t       exec_q[$];
  logic [15:0] stream_q[$];
  int          wait_cfg = 0;
  int          n_pass   = 0;
  int          n_total  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic push_fetch(input logic [7:0] a, input logic c, input logic s);
    fetch_t f;
    f.addr  = a;
    f.carry = c;
    f.skip  = s;
    fetch_q.push_back(f);
  endtask

  task automatic push_exec(input logic [15:0] ins, input logic we, input logic [1:0] wa,
                           input logic [1:0] ra, input logic chk, input logic c,
                           input logic s);
    exec_t e;
    e.instr     = ins;
    e.we        = we;
    e.waddr     = wa;
    e.raddr     = ra;
    e.chk_flags = chk;
    e.carry     = c;
    e.skip      = s;
    exec_q.push_back(e);
  endtask

  // Memory responder: after wait_cfg wait cycles, present the next stream word.
  always @(negedge clk) begin : mem_resp
    fetch_t f;
    int     wcnt;
    if (mem_req) begin
      if (wcnt < wait_cfg) begin
        mem_ready = 1'b0;
        wcnt++;
      end else if (stream_q.size() > 0) begin
        mem_rdata = stream_q.pop_front();
        mem_ready = 1'b1;
        wcnt      = 0;
        if (fetch_q.size() == 0) begin
          check("fetch_unexpected", 32'(mem_addr), 32'hffff_ffff);
        end else begin
          f = fetch_q.pop_front();
          check("fetch_addr", 32'(mem_addr), 32'(f.addr));
          check("fetch_carry", 32'(carrystatus), 32'(f.carry));
          check("fetch_skip", 32'(skipstatus), 32'(f.skip));
        end
      end else begin
        mem_ready = 1'b0;
      end
    end else begin
      mem_ready = 1'b0;
      wcnt      = 0;
    end
  end

  // Execute monitor: flags are checked in EXEC2, one cycle after the strobe.
  always begin : exec_mon
    exec_t e;
    @(negedge clk);
    if (exec1) begin
      if (exec_q.size() == 0) begin
        check("exec_unexpected", 32'(instruction), 32'hffff_ffff);
      end else begin
        e = exec_q.pop_front();
        check("exec_instr", 32'(instruction), 32'(e.instr));
        check("exec_rf_we", 32'(rf_we), 32'(e.we));
        check("exec_rf_waddr", 32'(rf_waddr), 32'(e.waddr));
        check("exec_rf_raddr", 32'(rf_raddr), 32'(e.raddr));
        if (e.chk_flags) begin
          @(negedge clk);
          check("exec2_carry", 32'(carrystatus), 32'(e.carry));
          check("exec2_skip", 32'(skipstatus), 32'(e.skip));
          check("exec2_strobe_low", 32'(exec1), 32'd0);
        end
      end
    end else begin
      check("rf_we_outside_exec1", 32'(rf_we), 32'd0);
    end
  end

  task automatic do_reset();
    reset    = 1'b1;
    start    = 1'b0;
    wait_cfg = 0;
    stream_q.delete();
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_halt(input int budget);
    int n = 0;
    while (!halted && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("halt_reached", 32'(halted), 32'd1);
  endtask

  initial begin : timeout
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : main
    int n;
    reset     = 1'b1;
    start     = 1'b0;
    mem_ready = 1'b0;
    mem_rdata = 16'h0000;
    @(negedge clk);
    @(negedge clk);
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_exec1", 32'(exec1), 32'd0);
    check("rst_rf_we", 32'(rf_we), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'h00);
    check("rst_instruction", 32'(instruction), 32'h0000);
    check("rst_carry", 32'(carrystatus), 32'd0);
    check("rst_skip", 32'(skipstatus), 32'd0);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("idle_no_req", 32'(mem_req), 32'd0);

    // Directed program: plain, carry set+write, carry clear, carry not enabled,
    // plain, skip at 0x05 (0x06 skipped), skip enabled with value 0, halt.
    stream_q = '{16'hC000, 16'hD309, 16'hC100, 16'hC200, 16'hC000, 16'hCC00,
                 16'hC400, 16'h1234};
    push_fetch(8'h00, 1'b0, 1'b0);
    push_fetch(8'h01, 1'b0, 1'b0);
    push_fetch(8'h02, 1'b1, 1'b0);
    push_fetch(8'h03, 1'b0, 1'b0);
    push_fetch(8'h04, 1'b0, 1'b0);
    push_fetch(8'h05, 1'b0, 1'b0);
    push_fetch(8'h07, 1'b0, 1'b0);
    push_fetch(8'h08, 1'b0, 1'b0);
    push_exec(16'hC000, 1'b0, 2'd0, 2'd0, 1'b1, 1'b0, 1'b0);
    push_exec(16'hD309, 1'b1, 2'd2, 2'd1, 1'b1, 1'b1, 1'b0);
    push_exec(16'hC100, 1'b0, 2'd0, 2'd0, 1'b1, 1'b0, 1'b0);
    push_exec(16'hC200, 1'b0, 2'd0, 2'd0, 1'b1, 1'b0, 1'b0);
    push_exec(16'hC000, 1'b0, 2'd0, 2'd0, 1'b1, 1'b0, 1'b0);
    push_exec(16'hCC00, 1'b0, 2'd0, 2'd0, 1'b1, 1'b0, 1'b1);
    push_exec(16'hC400, 1'b0, 2'd0, 2'd0, 1'b1, 1'b0, 1'b0);
    pulse_start();
    // Counting the start cycle as cycle 1: FETCH, DECODE, then EXEC1 in cycle 4.
    check("lat_fetch_req", 32'(mem_req), 32'd1);
    check("lat_fetch_exec1", 32'(exec1), 32'd0);
    @(negedge clk);
    check("lat_decode_exec1", 32'(exec1), 32'd0);
    check("lat_decode_ir", 32'(instruction), 32'hC000);
    check("lat_decode_req", 32'(mem_req), 32'd0);
    @(negedge clk);
    check("lat_exec1", 32'(exec1), 32'd1);
    check("lat_exec1_pc", 32'(mem_addr), 32'h01);
    wait_halt(200);
    check("halt_ir", 32'(instruction), 32'h1234);
    for (int i = 0; i < 20; i++) begin
      start = (i % 3 == 0);
      @(negedge clk);
      check("halt_held", 32'(halted), 32'd1);
      check("halt_no_req", 32'(mem_req), 32'd0);
      check("halt_no_exec1", 32'(exec1), 32'd0);
    end
    start = 1'b0;
    check("progA_exec_drained", 32'(exec_q.size()), 32'd0);
    check("progA_fetch_drained", 32'(fetch_q.size()), 32'd0);
    do_reset();
    check("reset_clears_halted", 32'(halted), 32'd0);
    check("reset_clears_carry_pc", 32'({mem_addr, carrystatus}), 32'h000);

    // Slow memory: 7 wait cycles per fetch; reset in the third wait cycle at 0x02.
    wait_cfg = 7;
    stream_q = '{16'hC000, 16'hC000, 16'hC000};
    push_fetch(8'h00, 1'b0, 1'b0);
    push_fetch(8'h01, 1'b0, 1'b0);
    push_exec(16'hC000, 1'b0, 2'd0, 2'd0, 1'b1, 1'b0, 1'b0);
    push_exec(16'hC000, 1'b0, 2'd0, 2'd0, 1'b1, 1'b0, 1'b0);
    pulse_start();
    for (int i = 0; i < 7; i++) begin
      check("wait_req_steady", 32'(mem_req), 32'd1);
      check("wait_addr_const", 32'(mem_addr), 32'h00);
      check("wait_no_decode", 32'(instruction), 32'h0000);
      @(negedge clk);
    end
    n = 0;
    while (!(mem_req && mem_addr == 8'h02) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("wait_reach_fetch2", 32'(mem_addr), 32'h02);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("waitrst_req", 32'(mem_req), 32'd0);
    check("waitrst_pc", 32'(mem_addr), 32'h00);
    check("waitrst_ir", 32'(instruction), 32'h0000);
    check("waitrst_exec_drained", 32'(exec_q.size()), 32'd0);
    do_reset();

    // Reset on the same edge that memory answers: IR and PC stay cleared.
    stream_q = '{16'hABCD};
    push_fetch(8'h00, 1'b0, 1'b0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("fetchrst_ir", 32'(instruction), 32'h0000);
    check("fetchrst_pc", 32'(mem_addr), 32'h00);
    check("fetchrst_req", 32'(mem_req), 32'd0);
    check("fetchrst_halted", 32'(halted), 32'd0);
    do_reset();

    // Reset during EXEC1 suppresses the carry and skip updates.
    stream_q = '{16'hCF00};
    push_fetch(8'h00, 1'b0, 1'b0);
    push_exec(16'hCF00, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    pulse_start();
    n = 0;
    while (!exec1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("execrst_reach_exec1", 32'(exec1), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("execrst_carry", 32'(carrystatus), 32'd0);
    check("execrst_skip", 32'(skipstatus), 32'd0);
    check("execrst_pc", 32'(mem_addr), 32'h00);
    do_reset();

    // Fetch at 0xFF wraps the PC to 0x00; the halt word is then fetched at 0x00.
    for (int i = 0; i < 256; i++) begin
      stream_q.push_back(16'hC000);
      push_fetch(8'(i), 1'b0, 1'b0);
      push_exec(16'hC000, 1'b0, 2'd0, 2'd0, 1'b1, 1'b0, 1'b0);
    end
    stream_q.push_back(16'h1234);
    push_fetch(8'h00, 1'b0, 1'b0);
    pulse_start();
    wait_halt(2000);
    check("fetchwrap_pc", 32'(mem_addr), 32'h01);
    check("fetchwrap_drained", 32'(fetch_q.size() + exec_q.size()), 32'd0);
    do_reset();

    // Skip taken at 0xFF: the word at 0xFE skips 0xFF and fetch resumes at 0x00.
    for (int i = 0; i < 254; i++) begin
      stream_q.push_back(16'hC000);
      push_fetch(8'(i), 1'b0, 1'b0);
      push_exec(16'hC000, 1'b0, 2'd0, 2'd0, 1'b1, 1'b0, 1'b0);
    end
    stream_q.push_back(16'hCC00);
    push_fetch(8'hFE, 1'b0, 1'b0);
    push_exec(16'hCC00, 1'b0, 2'd0, 2'd0, 1'b1, 1'b0, 1'b1);
    stream_q.push_back(16'h1234);
    push_fetch(8'h00, 1'b0, 1'b0);
    pulse_start();
    wait_halt(2000);
    check("skipwrap_pc", 32'(mem_addr), 32'h01);
    check("skipwrap_skip_clear", 32'(skipstatus), 32'd0);
    check("skipwrap_drained", 32'(fetch_q.size() + exec_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 SHALL have: clk  input  1  single system clock, all state updates on rising edge.
REQ-002 SHALL have: reset  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-003 SHALL have: start  input  1  one-cycle pulse leaving IDLE.
REQ-004 SHALL have: mem_rdata  input  16  instruction word from program memory.
REQ-005 SHALL have: mem_ready  input  1  mem_rdata valid this cycle.
REQ-006 SHALL have: mem_req  output  1  fetch request, held until mem_ready.
REQ-007 SHALL have: mem_addr  output  8  current PC.
REQ-008 SHALL have: instruction  output  16  IR' driven to the ALU.
REQ-009 SHALL have: exec1  output  1  ALU execute timing strobe.
REQ-010 SHALL have: carrystatus, skipstatus  output  1 each  CARRY / SKIP flip-flop Q.
REQ-011 SHALL have: carryout, carryen, skipout, skipen, wenout  input  1 each  ALU flag D/enable and Rd write enable.
REQ-012 SHALL have: rf_we  output  1; rf_waddr  output  2 (= IR[3:2], Rd); rf_raddr  output  2 (= IR[1:0], Rs).
REQ-013 SHALL have: halted  output  1  sequencer stopped on non-ALU instruction.

Function
REQ-014 States SHALL be IDLE, FETCH, DECODE, EXEC1, EXEC2, HALT; one state per cycle except FETCH/IDLE/HALT which may hold.
REQ-015 IDLE: all strobes 0; start=1 -> FETCH next cycle.
REQ-016 FETCH: mem_req=1, mem_addr=PC; on mem_ready=1 load IR<=mem_rdata, PC<=PC+1 (8-bit, FF wraps to 00), -> DECODE; mem_ready=0 holds FETCH indefinitely.
REQ-017 DECODE: IR[15:14]==2'b11 -> EXEC1; otherwise -> HALT.
REQ-018 EXEC1: exec1=1 for exactly one cycle; rf_we=wenout combinationally; on the clock edge CARRY<=carryout iff carryen, SKIP<=skipout iff skipen; -> EXEC2.
REQ-019 EXEC2: if SKIP==1 then PC<=PC+1 (wrapping) and SKIP<=0; -> FETCH.
REQ-020 Instruction latency SHALL be fetch-wait + 4 cycles (FETCH accept, DECODE, EXEC1, EXEC2) with zero-wait memory.
REQ-021 instruction output SHALL equal IR at all times, stable from DECODE through EXEC2.
REQ-022 rf_we SHALL be 0 in every state other than EXEC1.
REQ-023 HALT: halted=1, mem_req=0, exec1=0; leaves only via reset; start ignored.
REQ-024 start pulses outside IDLE SHALL be ignored.
REQ-025 CARRY and SKIP SHALL change only at EXEC1 (enable-qualified) and EXEC2 (SKIP clear); never in FETCH/DECODE.

Reset
REQ-026 reset=1 SHALL, on the next edge regardless of state, force IDLE, PC=0x00, IR=0x0000, CARRY=0, SKIP=0.
REQ-027 During/after reset: mem_req=0, exec1=0, rf_we=0, halted=0, mem_addr=0x00, instruction=0x0000.
REQ-028 Reset asserted mid-FETCH with mem_ready=1 SHALL take priority; IR and PC not updated.
REQ-029 Reset asserted in EXEC1 SHALL suppress the CARRY/SKIP update on that edge.

Verification
REQ-030 Reset, start, mem_rdata=0xC000 zero-wait -> mem_addr 0x00 then 0x01; exec1 high exactly cycle 4 after start accept; IR=0xC000.
REQ-031 In EXEC1 drive carryen=1, carryout=1, skipen=0 -> carrystatus=1 next cycle, skipstatus unchanged 0.
REQ-032 In EXEC1 drive skipen=1, skipout=1 at PC=0x05 -> EXEC2 PC becomes 0x06->0x07, next mem_addr=0x07, skipstatus returns 0.
REQ-033 PC=0xFF fetch with mem_ready=1 -> PC=0x00; skip from PC=0xFF wraps likewise.
REQ-034 mem_rdata=0x1234 (code 00) -> DECODE then HALT, halted=1, mem_req=0 for 20 cycles despite start pulses; reset clears halted.
REQ-035 mem_ready held 0 for 7 cycles then 1 -> FETCH held, mem_req=1 steady, mem_addr constant; reset in cycle 3 of wait -> IDLE, PC=0x00.
